// File: rtl/systolic_fp8_drain_if.sv
// Result stream from the systolic drain: one beat carries LANES FP8 elements of one row.
// m_valid/m_ready: a beat transfers on every rising edge where both are high; while m_valid is high and m_ready low, every other m_* signal holds.
interface systolic_fp8_drain_if #(
    parameter int LANES = 4,
    parameter int IDX_W = 4
);
    logic                 m_valid;
    logic                 m_ready;
    logic [8*LANES-1:0]   m_data;
    logic [IDX_W-1:0]     m_row;
    logic [IDX_W-1:0]     m_col;
    logic                 m_last;

    modport master (
        output m_valid, m_data, m_row, m_col, m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid, m_data, m_row, m_col, m_last,
        output m_ready
    );
endinterface

// File: rtl/systolic_fp8_drain.sv
// Waits a programmable settle time after start, snapshots the array result bus,
// then streams the N x N FP8 matrix row-major, LANES elements per beat.
module systolic_fp8_drain #(
    parameter int N     = 16,
    parameter int LANES = 4,
    parameter int CNT_W = 8,
    parameter int IDX_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_W-1:0]     settle_cycles,
    input  logic [8*N*N-1:0]     C_bus,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           state_dbg,
    systolic_fp8_drain_if.master m
);
    typedef enum logic [1:0] {IDLE, SETTLE, STREAM, DONE} state_t;

    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(N - LANES);
    localparam logic [IDX_W-1:0] COL_STEP = IDX_W'(LANES);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0] row_q, col_q;
    logic [7:0]       snap_q [N][N];
    logic             at_row_end, at_last, xfer;

    assign at_row_end = (col_q == LAST_COL);
    assign at_last    = at_row_end && (row_q == LAST_ROW);
    assign xfer       = (state_q == STREAM) && m.m_ready;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SETTLE;
            SETTLE:  if (cnt_q == '0) state_d = STREAM;
            STREAM:  if (xfer && at_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are zero outside STREAM so a finished drain leaves a quiet bus.
    always_comb begin
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
        state_dbg = state_q;
        m.m_valid = (state_q == STREAM);
        m.m_last  = m.m_valid && at_last;
        m.m_row   = m.m_valid ? row_q : '0;
        m.m_col   = m.m_valid ? col_q : '0;
        m.m_data  = '0;
        if (m.m_valid) begin
            for (int k = 0; k < LANES; k++) begin
                m.m_data[8*k +: 8] = snap_q[row_q][col_q + IDX_W'(k)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            row_q <= '0;
            col_q <= '0;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    snap_q[r][c] <= '0;
                end
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cnt_q <= settle_cycles;
                        row_q <= '0;
                        col_q <= '0;
                    end
                end
                SETTLE: begin
                    if (cnt_q == '0) begin
                        for (int r = 0; r < N; r++) begin
                            for (int c = 0; c < N; c++) begin
                                snap_q[r][c] <= C_bus[(r*N + c)*8 +: 8];
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        if (at_row_end) begin
                            col_q <= '0;
                            // Wrap to (0,0) after the last beat so indices stay in range.
                            row_q <= at_last ? '0 : row_q + 1'b1;
                        end else begin
                            col_q <= col_q + COL_STEP;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_systolic_fp8_drain.sv
// Directed bench for systolic_fp8_drain at N=4, LANES=2: reset, timing, backpressure,
// ignored starts and mid-stream reset, with expected beats held in a queue.
module tb_systolic_fp8_drain;
    localparam int N     = 4;
    localparam int LANES = 2;
    localparam int CNT_W = 8;
    localparam int IDX_W = 2;
    localparam int BEATS = N*N/LANES;
    localparam int W     = 8*LANES;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] settle_cycles = '0;
    logic [8*N*N-1:0] c_bus = '0;
    logic             busy, done;
    logic [1:0]       state_dbg;

    systolic_fp8_drain_if #(.LANES(LANES), .IDX_W(IDX_W)) m_if ();

    systolic_fp8_drain #(.N(N), .LANES(LANES), .CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .start(start), .settle_cycles(settle_cycles),
        .C_bus(c_bus), .busy(busy), .done(done), .state_dbg(state_dbg), .m(m_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];
    bit churn = 1'b0;
    int churn_v = 0;
    bit rdy_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [W-1:0] basic_tab [BEATS] = '{16'h0100, 16'h0302, 16'h1110, 16'h1312,
                                        16'h2120, 16'h2322, 16'h3130, 16'h3332};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] churn_elem(input int v, input int r, input int c);
        return 8'((v*37 + r*4 + c) & 255);
    endfunction

    task automatic set_churn(input int v);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                c_bus[(r*N + c)*8 +: 8] = churn_elem(v, r, c);
    endtask

    task automatic set_basic();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                c_bus[(r*N + c)*8 +: 8] = 8'(16*r + c);
    endtask

    task automatic load_exp_basic();
        exp_q.delete();
        for (int b = 0; b < BEATS; b++) exp_q.push_back(basic_tab[b]);
    endtask

    task automatic load_exp_churn(input int v);
        exp_q.delete();
        for (int b = 0; b < BEATS; b++)
            exp_q.push_back({churn_elem(v, b/2, (b%2)*2 + 1), churn_elem(v, b/2, (b%2)*2)});
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (churn) begin
            churn_v++;
            set_churn(churn_v);
        end
    endtask

    task automatic do_start(input int settle, input bit glitch);
        start = 1'b1;
        settle_cycles = CNT_W'(settle);
        tick();
        if (!glitch) start = 1'b0;
        chk("settle_busy", busy, 1);
        chk("settle_valid_low", m_if.m_valid, 0);
        for (int i = 0; i < settle; i++) begin
            tick();
            if (i == 0) start = 1'b0;
        end
        chk("pre_valid_low", m_if.m_valid, 0);
        tick();
        chk("valid_rise", m_if.m_valid, 1);
    endtask

    task automatic drain(input int mode, input int abort_at, input bit poke_start);
        int b = 0;
        int cyc = 0;
        bit have_prev = 1'b0;
        logic [W-1:0] prev_data = '0;
        logic [IDX_W-1:0] prev_row = '0, prev_col = '0;
        int target = (abort_at >= 0) ? abort_at : BEATS;
        while (b < target && cyc < 200) begin
            m_if.m_ready = (mode == 0) ? 1'b1 : rdy_pat[cyc % 6];
            start = poke_start && (cyc == 3);
            chk("stream_valid", m_if.m_valid, 1);
            if (have_prev) begin
                chk("hold_data", m_if.m_data, prev_data);
                chk("hold_row", m_if.m_row, prev_row);
                chk("hold_col", m_if.m_col, prev_col);
            end
            if (m_if.m_ready) begin
                chk("beat_data", m_if.m_data, exp_q.pop_front());
                chk("beat_row", m_if.m_row, b / 2);
                chk("beat_col", m_if.m_col, (b % 2) * LANES);
                chk("beat_last", m_if.m_last, (b == BEATS - 1));
                b++;
                have_prev = 1'b0;
            end else begin
                prev_data = m_if.m_data;
                prev_row  = m_if.m_row;
                prev_col  = m_if.m_col;
                have_prev = 1'b1;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        chk("beat_count", b, target);
        if (abort_at < 0) begin
            chk("done_pulse", done, 1);
            chk("done_busy", busy, 1);
            chk("done_valid_low", m_if.m_valid, 0);
            tick();
            chk("done_clear", done, 0);
            chk("idle_busy", busy, 0);
        end
    endtask

    task automatic idle_checks(input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) begin
            m_if.m_ready = ~m_if.m_ready;
            tick();
            chk({tag, "_valid"}, m_if.m_valid, 0);
            chk({tag, "_busy"}, busy, 0);
            chk({tag, "_done"}, done, 0);
        end
    endtask

    initial begin
        m_if.m_ready = 1'b0;
        // Scenario 1: reset and idle
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_valid", m_if.m_valid, 0);
        chk("rst_last", m_if.m_last, 0);
        chk("rst_done", done, 0);
        chk("rst_data", m_if.m_data, 0);
        chk("rst_row", m_if.m_row, 0);
        chk("rst_col", m_if.m_col, 0);
        chk("rst_state", state_dbg, 0);
        idle_checks(4, "idle_ready");

        // Scenario 2: basic drain
        set_basic();
        load_exp_basic();
        do_start(0, 1'b0);
        drain(0, -1, 1'b0);

        // Scenario 3: settle timing with a changing bus
        churn_v = 0;
        set_churn(0);
        churn = 1'b1;
        load_exp_churn(6);
        do_start(5, 1'b0);
        drain(0, -1, 1'b0);
        churn = 1'b0;

        // Scenario 4: backpressure
        set_basic();
        load_exp_basic();
        do_start(0, 1'b0);
        drain(1, -1, 1'b0);

        // Scenario 5: starts during SETTLE and STREAM are ignored
        load_exp_basic();
        do_start(3, 1'b1);
        drain(0, -1, 1'b1);
        idle_checks(3, "no_restart");

        // Scenario 6: reset after three accepted beats
        load_exp_basic();
        do_start(0, 1'b0);
        drain(0, 3, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_valid", m_if.m_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        tick();
        chk("abort_no_done", done, 0);
        load_exp_basic();
        do_start(0, 1'b0);
        drain(0, -1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/systolic_fp8_drain.md
Name: systolic_fp8_drain

Overview:
- Result-side reader for the FP8 systolic array. The array produces the flat result bus C_bus; this block reads it.
- On a start pulse, the block waits a programmable settle interval, then snapshots C_bus.
- It then streams the N×N FP8 results row-major over a valid/ready stream, LANES elements per beat.
- It sits between the array output and the result write-back path.

Parameters:
- N, 16, array dimension; the snapshot holds N*N FP8 elements.
- LANES, 4, FP8 elements per output beat; must divide N.
- CNT_W, 8, width of the settle counter.
- IDX_W, 4, width of the row/column index outputs; must satisfy 2^IDX_W >= N.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a drain; sampled only in IDLE.
- settle_cycles  input  CNT_W  cycles to wait after start before the snapshot; sampled together with start.
- C_bus  input  8*N*N  array results; element (r,c) at bits [(r*N+c+1)*8-1 -: 8].
- busy  output  1  high in every state except IDLE.
- m_valid  output  1  output beat valid.
- m_ready  input  1  downstream accept.
- m_data  output  8*LANES  lane k at bits [8k+7:8k] = element (row, col+k).
- m_row  output  IDX_W  row index of the current beat.
- m_col  output  IDX_W  column of lane 0 of the current beat; always a multiple of LANES.
- m_last  output  1  high on the final beat (row N-1, col N-LANES).
- done  output  1  one-cycle pulse after the final beat is accepted.

Behaviour:
- Reset: when rst is high at a rising edge, the following are cleared.
  - State goes to IDLE.
  - busy, m_valid, m_last and done go to 0.
  - m_data, m_row, m_col, the counter and the snapshot go to 0.
  - Reset overrides everything, including mid-stream; any partial drain is abandoned with no done pulse.
- States: IDLE, SETTLE, STREAM, DONE.
- IDLE:
  - start=1 at edge E0: load cnt <= settle_cycles, row/col <= 0, go to SETTLE.
  - start=0: stay in IDLE.
- SETTLE:
  - At each edge, if cnt==0, then snapshot <= C_bus and go to STREAM.
  - Otherwise cnt <= cnt-1.
  - The snapshot is therefore taken at edge E0+settle_cycles+1.
  - m_valid first rises after that edge; for settle_cycles=0 it rises 2 cycles after start is sampled.
- STREAM:
  - m_valid=1.
  - m_data, m_row, m_col and m_last are driven combinationally from the snapshot and the registered row/col.
  - A beat transfers on any edge where m_valid & m_ready.
  - On transfer: if col == N-LANES, then col <= 0 and row <= row+1; otherwise col <= col+LANES.
  - On the final beat's transfer (m_last=1), go to DONE.
  - With m_ready low, all m_* outputs hold stable; no beat is dropped or repeated.
  - Beat order is strictly row-major; total beats = N*N/LANES.
- DONE:
  - done=1 and busy=1 for exactly one cycle, m_valid=0.
  - Next state is IDLE.
  - The earliest next start is accepted on the cycle after DONE.
- start outside IDLE: ignored, with no queuing. A start coincident with the DONE cycle is dropped.
- C_bus changes after the snapshot do not affect streamed data.
- m_ready while m_valid=0 has no effect.
- Counter wrap: cnt never underflows; settle_cycles = 2^CNT_W-1 gives the maximum wait.
- Data is passed through unmodified; the block has no FP8 arithmetic.

Test Plan:
1. Reset/idle (N=4, LANES=2): assert rst 3 cycles, then release. Required: all outputs 0, busy=0. Toggling m_ready alone causes no activity.
2. Basic drain (N=4, LANES=2): element (r,c) = 8'h10*r+c; start with settle_cycles=0, m_ready=1. Required:
   - m_valid rises 2 cycles after start.
   - 8 consecutive beats: m_data = 16'h0100, 16'h0302, 16'h1110, ... 16'h3332.
   - m_last only on beat 8.
   - done pulses the cycle after beat 8; busy falls after that.
3. Settle timing: settle_cycles=5, C_bus changes every cycle to a counter value. Required: the streamed data equals the C_bus value present just before edge E0+6.
4. Backpressure: m_ready pattern 1,0,0,1,0,1,... Required:
   - m_data/m_row/m_col are held during stalls.
   - The sequence is identical to scenario 2.
   - The beat count is exactly 8.
5. Ignored start: pulse start during SETTLE and again during STREAM. Required: the drain completes once with no restart and exactly one done.
6. Mid-stream reset: rst asserted after beat 3 is accepted. Required:
   - Next cycle m_valid=0 and busy=0, with no done.
   - A new start afterwards drains all beats from (0,0).
